// File: rtl/maze_probe_engine_pkg.sv
`default_nettype none
// ============================================================================
// ball_maze_pkg : shared enums and constants for the ball-maze probe path
// Revision 1.0
// ============================================================================
package ball_maze_pkg;

    typedef enum logic [2:0] {
        PRB_RIGHT  = 3'd0,
        PRB_LEFT   = 3'd1,
        PRB_UP     = 3'd2,
        PRB_DOWN   = 3'd3,
        PRB_CENTER = 3'd4
    } probe_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } probe_state_e;

    // Field order matches the packed {right, left, above, below} debug vector
    typedef struct packed {
        logic right;
        logic left;
        logic above;
        logic below;
    } walls_t;

    localparam int WIN_HOLD_DEFAULT = 216_000_000;
    localparam int NUM_PROBES       = 5;
    localparam int ROM_LATENCY      = 2;

endpackage
`default_nettype wire

// File: rtl/maze_probe_engine_if.sv
`default_nettype none
// ============================================================================
// maze_probe_engine_if : probe request/response bundle plus tile-ROM loader
// Revision 1.0
// ============================================================================
interface maze_probe_engine_if #(
    parameter int MAP_COLS_LOG2 = 5,
    parameter int MAP_ROWS_LOG2 = 5,
    parameter int TILE_LOG2     = 3,
    parameter int TILE_TYPE_W   = 6,
    parameter int PIX_W         = 2
);
    localparam int COL_W  = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int ROW_W  = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int MAP_AW = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int SET_AW = TILE_TYPE_W + 2 * TILE_LOG2;

    logic             probeStart;
    logic [COL_W-1:0] ballColumn;
    logic [ROW_W-1:0] ballRow;
    logic             dbgEn;
    logic [3:0]       dbgWalls;
    logic             probeBusy;
    logic             probeDone;
    logic             wallRightOfball;
    logic             wallLeftOfball;
    logic             wallAboveball;
    logic             wallBelowball;
    logic             winGame;

    // Tile map / tile set contents are streamed in by the boot loader
    logic                   tileMapWe;
    logic [MAP_AW-1:0]      tileMapAddr;
    logic [TILE_TYPE_W-1:0] tileMapData;
    logic                   tileSetWe;
    logic [SET_AW-1:0]      tileSetAddr;
    logic [PIX_W-1:0]       tileSetData;

    modport master (
        output probeStart, ballColumn, ballRow, dbgEn, dbgWalls,
        output tileMapWe, tileMapAddr, tileMapData,
        output tileSetWe, tileSetAddr, tileSetData,
        input  probeBusy, probeDone,
        input  wallRightOfball, wallLeftOfball, wallAboveball, wallBelowball,
        input  winGame
    );

    modport slave (
        input  probeStart, ballColumn, ballRow, dbgEn, dbgWalls,
        input  tileMapWe, tileMapAddr, tileMapData,
        input  tileSetWe, tileSetAddr, tileSetData,
        output probeBusy, probeDone,
        output wallRightOfball, wallLeftOfball, wallAboveball, wallBelowball,
        output winGame
    );

endinterface
`default_nettype wire

// File: rtl/maze_probe_engine_tile_pixel_rom.sv
`default_nettype none
// ============================================================================
// tile_pixel_rom : map + tile-set block memories, 2-cycle (column,row)->pixel
// Revision 1.0
// ============================================================================
module tile_pixel_rom #(
    parameter int MAP_COLS_LOG2 = 5,
    parameter int MAP_ROWS_LOG2 = 5,
    parameter int TILE_LOG2     = 3,
    parameter int TILE_TYPE_W   = 6,
    parameter int PIX_W         = 2
) (
    input  logic                                       clk,
    input  logic [MAP_COLS_LOG2+TILE_LOG2-1:0]         i_col,
    input  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]         i_row,
    output logic [PIX_W-1:0]                           o_pix,
    input  logic                                       i_map_we,
    input  logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0]     i_map_addr,
    input  logic [TILE_TYPE_W-1:0]                     i_map_data,
    input  logic                                       i_set_we,
    input  logic [TILE_TYPE_W+2*TILE_LOG2-1:0]         i_set_addr,
    input  logic [PIX_W-1:0]                           i_set_data
);
    localparam int COL_W     = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int ROW_W     = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int MAP_DEPTH = 1 << (MAP_COLS_LOG2 + MAP_ROWS_LOG2);
    localparam int SET_DEPTH = 1 << (TILE_TYPE_W + 2 * TILE_LOG2);

    logic [TILE_TYPE_W-1:0] r_map [MAP_DEPTH];
    logic [PIX_W-1:0]       r_set [SET_DEPTH];

    logic [TILE_TYPE_W-1:0] r_tile;
    logic [2*TILE_LOG2-1:0] r_sub;
    logic [PIX_W-1:0]       r_pix;

    // No reset on purpose: keeps both arrays mappable onto block RAM
    always_ff @(posedge clk) begin
        if (i_map_we) begin
            r_map[i_map_addr] <= i_map_data;
        end
        if (i_set_we) begin
            r_set[i_set_addr] <= i_set_data;
        end
        r_tile <= r_map[{i_row[ROW_W-1:TILE_LOG2], i_col[COL_W-1:TILE_LOG2]}];
        r_sub  <= {i_row[TILE_LOG2-1:0], i_col[TILE_LOG2-1:0]};
        r_pix  <= r_set[{r_tile, r_sub}];
    end

    assign o_pix = r_pix;

endmodule
`default_nettype wire

// File: rtl/maze_probe_engine.sv
`default_nettype none
// ============================================================================
// maze_probe_engine : time-multiplexed 5-point wall/goal probe with win hold
// Revision 1.0
// ============================================================================
module maze_probe_engine
    import ball_maze_pkg::*;
#(
    parameter int MAP_COLS_LOG2 = 5,
    parameter int MAP_ROWS_LOG2 = 5,
    parameter int TILE_LOG2     = 3,
    parameter int TILE_TYPE_W   = 6,
    parameter int PIX_W         = 2,
    parameter int PROBE_OFS     = 8,
    parameter int WALL_IDX      = 1,
    parameter int GOAL_IDX      = 2,
    parameter int WIN_HOLD      = WIN_HOLD_DEFAULT
) (
    input  logic              clk108MHz,
    input  logic              resetPressed,
    maze_probe_engine_if.slave prb
);
    localparam int COL_W  = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int ROW_W  = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int HOLD_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

    localparam logic [COL_W-1:0]  c_col_ofs    = COL_W'(PROBE_OFS);
    localparam logic [ROW_W-1:0]  c_row_ofs    = ROW_W'(PROBE_OFS);
    localparam logic [PIX_W-1:0]  c_wall_pix   = PIX_W'(WALL_IDX);
    localparam logic [PIX_W-1:0]  c_goal_pix   = PIX_W'(GOAL_IDX);
    localparam logic [HOLD_W-1:0] c_hold_load  = HOLD_W'(WIN_HOLD - 1);
    localparam logic [2:0]        c_last_probe = 3'(NUM_PROBES - 1);
    localparam logic [2:0]        c_last_drain = 3'(ROM_LATENCY - 1);

    probe_state_e     r_state;
    logic [2:0]       r_cnt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_dbg;
    logic [COL_W-1:0] r_prb_col;
    logic [ROW_W-1:0] r_prb_row;
    logic             r_vld_d0, r_vld_d1, r_vld_d2;
    probe_e           r_tag_d0, r_tag_d1, r_tag_d2;
    walls_t           r_shadow;
    walls_t           r_walls;
    logic             r_busy;
    logic             r_done;
    logic             r_win;
    logic [HOLD_W-1:0] r_hold;

    logic [COL_W-1:0] w_prb_col;
    logic [ROW_W-1:0] w_prb_row;
    logic [PIX_W-1:0] w_pix;
    logic             w_wall;
    logic             w_center_goal;
    logic             w_win_trig;

    // Offsets wrap modulo the map size, so edge probes see the opposite side
    always_comb begin
        w_prb_col = r_col;
        w_prb_row = r_row;
        case (probe_e'(r_cnt))
            PRB_RIGHT: w_prb_col = r_col + c_col_ofs;
            PRB_LEFT:  w_prb_col = r_col - c_col_ofs;
            PRB_UP:    w_prb_row = r_row - c_row_ofs;
            PRB_DOWN:  w_prb_row = r_row + c_row_ofs;
            default:   ;
        endcase
    end

    tile_pixel_rom #(
        .MAP_COLS_LOG2 (MAP_COLS_LOG2),
        .MAP_ROWS_LOG2 (MAP_ROWS_LOG2),
        .TILE_LOG2     (TILE_LOG2),
        .TILE_TYPE_W   (TILE_TYPE_W),
        .PIX_W         (PIX_W)
    ) u_rom (
        .clk        (clk108MHz),
        .i_col      (r_prb_col),
        .i_row      (r_prb_row),
        .o_pix      (w_pix),
        .i_map_we   (prb.tileMapWe),
        .i_map_addr (prb.tileMapAddr),
        .i_map_data (prb.tileMapData),
        .i_set_we   (prb.tileSetWe),
        .i_set_addr (prb.tileSetAddr),
        .i_set_data (prb.tileSetData)
    );

    assign w_wall        = (w_pix == c_wall_pix);
    assign w_center_goal = r_vld_d2 && (r_tag_d2 == PRB_CENTER) && (w_pix == c_goal_pix);
    assign w_win_trig    = (r_state == DONE) && !r_dbg && w_center_goal;

    always_ff @(posedge clk108MHz or posedge resetPressed) begin
        if (resetPressed) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_col     <= '0;
            r_row     <= '0;
            r_dbg     <= 1'b0;
            r_prb_col <= '0;
            r_prb_row <= '0;
            r_vld_d0  <= 1'b0;
            r_tag_d0  <= PRB_RIGHT;
            r_walls   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_vld_d0 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (prb.probeStart) begin
                        r_col   <= prb.ballColumn;
                        r_row   <= prb.ballRow;
                        r_dbg   <= prb.dbgEn;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_prb_col <= w_prb_col;
                    r_prb_row <= w_prb_row;
                    r_vld_d0  <= 1'b1;
                    r_tag_d0  <= probe_e'(r_cnt);
                    if (r_cnt == c_last_probe) begin
                        r_cnt   <= 3'd0;
                        r_state <= DRAIN;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                DRAIN: begin
                    if (r_cnt == c_last_drain) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                DONE: begin
                    r_walls <= r_dbg ? walls_t'(prb.dbgWalls) : r_shadow;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result tags travel alongside the ROM pipeline; visible flags only move at DONE
    always_ff @(posedge clk108MHz or posedge resetPressed) begin
        if (resetPressed) begin
            r_vld_d1 <= 1'b0;
            r_vld_d2 <= 1'b0;
            r_tag_d1 <= PRB_RIGHT;
            r_tag_d2 <= PRB_RIGHT;
            r_shadow <= '0;
        end else begin
            r_vld_d1 <= r_vld_d0;
            r_tag_d1 <= r_tag_d0;
            r_vld_d2 <= r_vld_d1;
            r_tag_d2 <= r_tag_d1;
            if (r_vld_d2) begin
                case (r_tag_d2)
                    PRB_RIGHT: r_shadow.right <= w_wall;
                    PRB_LEFT:  r_shadow.left  <= w_wall;
                    PRB_UP:    r_shadow.above <= w_wall;
                    PRB_DOWN:  r_shadow.below <= w_wall;
                    default:   ;
                endcase
            end
        end
    end

    // A goal hit during an active hold neither restarts nor stretches it
    always_ff @(posedge clk108MHz or posedge resetPressed) begin
        if (resetPressed) begin
            r_win  <= 1'b0;
            r_hold <= '0;
        end else if (r_win) begin
            if (r_hold == '0) begin
                r_win  <= 1'b0;
            end else begin
                r_hold <= r_hold - 1'b1;
            end
        end else if (w_win_trig) begin
            r_win  <= 1'b1;
            r_hold <= c_hold_load;
        end
    end

    assign prb.probeBusy       = r_busy;
    assign prb.probeDone       = r_done;
    assign prb.wallRightOfball = r_walls.right;
    assign prb.wallLeftOfball  = r_walls.left;
    assign prb.wallAboveball   = r_walls.above;
    assign prb.wallBelowball   = r_walls.below;
    assign prb.winGame         = r_win;

endmodule
`default_nettype wire

// File: tb/tb_maze_probe_engine.sv
`default_nettype none
// ============================================================================
// tb_maze_probe_engine : directed scoreboard bench for maze_probe_engine
// Revision 1.0
// ============================================================================
module tb_maze_probe_engine;
    import ball_maze_pkg::*;

    localparam int TB_HOLD = 16;

    typedef struct {
        logic [3:0] walls;
        string      tag;
    } exp_t;

    logic clk108MHz    = 1'b0;
    logic resetPressed = 1'b1;
    int   n_tests      = 0;
    int   n_fail       = 0;
    int   n_done       = 0;
    int   win_cycles   = 0;
    exp_t sb[$];

    maze_probe_engine_if bus ();

    maze_probe_engine #(
        .WIN_HOLD (TB_HOLD)
    ) dut (
        .clk108MHz    (clk108MHz),
        .resetPressed (resetPressed),
        .prb          (bus)
    );

    always #5 clk108MHz = ~clk108MHz;

    function automatic logic [3:0] walls_now();
        return {bus.wallRightOfball, bus.wallLeftOfball, bus.wallAboveball, bus.wallBelowball};
    endfunction

    function automatic logic [6:0] outs_now();
        return {bus.probeBusy, bus.probeDone, walls_now(), bus.winGame};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk108MHz);
        #1;
    endtask

    task automatic set_map(input int tr, input int tc, input int t);
        bus.tileMapWe   = 1'b1;
        bus.tileMapAddr = 10'(tr * 32 + tc);
        bus.tileMapData = 6'(t);
        tick();
        bus.tileMapWe   = 1'b0;
    endtask

    task automatic run_probe(input logic [7:0] col, input logic [7:0] row, input logic dbg,
                             input logic [3:0] dbgw, input logic [3:0] exp_w,
                             input logic exp_win, input string tag);
        exp_t e;
        int   n;
        bus.ballColumn = col;
        bus.ballRow    = row;
        bus.dbgEn      = dbg;
        bus.dbgWalls   = dbgw;
        bus.probeStart = 1'b1;
        e.walls = exp_w;
        e.tag   = tag;
        sb.push_back(e);
        tick();
        bus.probeStart = 1'b0;
        chk({tag, "_busy_e0"}, 32'(bus.probeBusy), 32'd1);
        n = 0;
        while (bus.probeDone !== 1'b1 && n < 20) begin
            tick();
            n++;
            chk({tag, "_busy"}, 32'(bus.probeBusy), 32'd1);
        end
        chk({tag, "_done_edge"}, 32'(n), 32'd8);
        chk({tag, "_win"}, 32'(bus.winGame), 32'(exp_win));
        tick();
        chk({tag, "_busy_e9"}, 32'({bus.probeBusy, bus.probeDone}), 32'd0);
    endtask

    // Scoreboard consumer: every probeDone must match the oldest outstanding request
    always @(negedge clk108MHz) begin
        exp_t e;
        if (bus.winGame === 1'b1) win_cycles++;
        if (resetPressed === 1'b0 && bus.probeDone === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_done: observed probeDone=1 expected 0");
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_walls"}, 32'(walls_now()), 32'(e.walls));
            end
        end
    end

    initial begin
        #300000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nd0;
        bus.probeStart  = 1'b0;
        bus.ballColumn  = '0;
        bus.ballRow     = '0;
        bus.dbgEn       = 1'b0;
        bus.dbgWalls    = 4'b0000;
        bus.tileMapWe   = 1'b0;
        bus.tileMapAddr = '0;
        bus.tileMapData = '0;
        bus.tileSetWe   = 1'b0;
        bus.tileSetAddr = '0;
        bus.tileSetData = '0;

        repeat (3) tick();
        chk("reset_outs", 32'(outs_now()), 32'd0);

        // Tile 0 open, 1 solid wall, 2 solid goal, 3 open with one wall pixel at (0,0)
        for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < 64; p++) begin
                bus.tileSetWe   = 1'b1;
                bus.tileSetAddr = 12'(t * 64 + p);
                bus.tileSetData = (t == 1) ? 2'd1 : (t == 2) ? 2'd2 : (t == 3 && p == 0) ? 2'd1 : 2'd0;
                tick();
            end
        end
        bus.tileSetWe = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            bus.tileMapWe   = 1'b1;
            bus.tileMapAddr = 10'(i);
            bus.tileMapData = 6'd0;
            tick();
        end
        bus.tileMapWe = 1'b0;

        resetPressed = 1'b0;
        tick();
        chk("post_reset_outs", 32'(outs_now()), 32'd0);

        run_probe(8'h40, 8'h40, 1'b0, 4'b0000, 4'b0000, 1'b0, "open");

        set_map(8, 9, 3);
        run_probe(8'h40, 8'h40, 1'b0, 4'b0000, 4'b1000, 1'b0, "right_wall");

        set_map(8, 31, 1);
        run_probe(8'h04, 8'h40, 1'b0, 4'b0000, 4'b0100, 1'b0, "left_wrap");

        set_map(15, 12, 1);
        set_map(17, 12, 1);
        run_probe(8'h60, 8'h80, 1'b0, 4'b0000, 4'b0011, 1'b0, "up_down");

        set_map(20, 20, 2);
        win_cycles = 0;
        run_probe(8'hA4, 8'hA4, 1'b0, 4'b0000, 4'b0000, 1'b1, "goal1");
        run_probe(8'hA4, 8'hA4, 1'b0, 4'b0000, 4'b0000, 1'b1, "goal2");
        n = 0;
        while (bus.winGame === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("win_dropped", 32'(bus.winGame), 32'd0);
        chk("win_cycles", 32'(win_cycles), 32'(TB_HOLD));

        run_probe(8'hA4, 8'hA4, 1'b1, 4'b1010, 4'b1010, 1'b0, "dbg_goal");
        repeat (4) tick();
        chk("dbg_no_win", 32'(bus.winGame), 32'd0);

        // Second start inside the probe window must be ignored
        nd0 = n_done;
        bus.ballColumn = 8'h40;
        bus.ballRow    = 8'h40;
        bus.dbgEn      = 1'b0;
        begin
            exp_t e;
            e.walls = 4'b1000;
            e.tag   = "double_start";
            sb.push_back(e);
        end
        bus.probeStart = 1'b1;
        tick();
        bus.probeStart = 1'b0;
        tick();
        tick();
        bus.probeStart = 1'b1;
        tick();
        bus.probeStart = 1'b0;
        n = 3;
        while (bus.probeDone !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("double_start_done_edge", 32'(n), 32'd8);
        repeat (15) tick();
        chk("double_start_done_count", 32'(n_done - nd0), 32'd1);

        // Goal with a wall on its right, then a probe aborted by reset mid-flight
        set_map(24, 24, 2);
        set_map(24, 25, 1);
        run_probe(8'hC4, 8'hC4, 1'b0, 4'b0000, 4'b1000, 1'b1, "goal3");
        nd0 = n_done;
        bus.ballColumn = 8'h40;
        bus.ballRow    = 8'h40;
        bus.probeStart = 1'b1;
        tick();
        bus.probeStart = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_abort_win", 32'(bus.winGame), 32'd1);
        resetPressed = 1'b1;
        tick();
        chk("abort_outs", 32'(outs_now()), 32'd0);
        resetPressed = 1'b0;
        repeat (15) tick();
        chk("abort_no_done", 32'(n_done - nd0), 32'd0);
        chk("abort_outs_after", 32'(outs_now()), 32'd0);

        run_probe(8'h40, 8'h40, 1'b0, 4'b0000, 4'b1000, 1'b0, "recover");

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
